// File: rtl/adcfmt_pkg.sv
// Shared constants and width helpers for the ADC sample formatter slice.
package adcfmt_pkg;

  localparam int SIGNED_IN_UNSIGNED   = 0;
  localparam int SIGNED_IN_OFFSET_BIN = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit tag so every port has a width.
  function automatic int chan_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  function automatic int entry_width(input int width, input int cw);
    return width + cw;
  endfunction

endpackage

// File: rtl/adcfmt_queue.sv
// Two-entry FIFO with a registered ready; holds {data, chan} words for the formatter.
module adcfmt_queue #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_next;
  logic          push;
  logic          pop;

  assign push      = push_valid & push_ready;
  assign pop       = pop_valid & pop_ready;
  assign pop_valid = (count != 2'd0);
  assign pop_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Ready comes from the next count, so it never depends combinationally on pop_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      push_ready <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      count      <= count_next;
      push_ready <= (count_next != 2'd2);
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/adc_sample_formatter.sv
// Formats raw ADC codes into signed filter words with a channel-tagged 2-entry queue.
// Define ADCFMT_DECIM2_EN to average each channel's sample pairs (2:1 decimation).
module adc_sample_formatter
  import adcfmt_pkg::*;
#(
  parameter  int ADC_WIDTH  = 12,
  parameter  int WIDTH      = 23,
  parameter  int FRAC_SHIFT = 2,
  parameter  int CHANNELS   = 1,
  parameter  int SIGNED_IN  = 0,
  localparam int CW         = chan_width(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADC_WIDTH-1:0]    in_data,
  input  logic [CW-1:0]           in_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CW-1:0]           out_chan,
  output logic                    out_last,
  output logic                    chan_err
);

  localparam int          ENTRY_W    = entry_width(WIDTH, CW);
  localparam logic [CW:0] CHAN_LIMIT = (CW + 1)'(CHANNELS);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  if (ADC_WIDTH + FRAC_SHIFT + 1 > WIDTH) begin : g_width_check
    $error("adc_sample_formatter: ADC_WIDTH+FRAC_SHIFT+1 exceeds WIDTH");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_chan_check
    $error("adc_sample_formatter: CHANNELS must be 1..16");
  end

  logic [WIDTH-1:0]   ext;
  logic [WIDTH-1:0]   fmt;
  logic               chan_ok;
  logic               enq_valid;
  logic [WIDTH-1:0]   enq_data;
  logic [ENTRY_W-1:0] head;

  if (SIGNED_IN == SIGNED_IN_OFFSET_BIN) begin : g_offset_bin
    logic [ADC_WIDTH-1:0] code;
    assign code = {~in_data[ADC_WIDTH-1], in_data[ADC_WIDTH-2:0]};
    assign ext  = {{(WIDTH - ADC_WIDTH){code[ADC_WIDTH-1]}}, code};
  end else begin : g_unsigned
    assign ext = {{(WIDTH - ADC_WIDTH){1'b0}}, in_data};
  end

  assign fmt     = ext << FRAC_SHIFT;
  assign chan_ok = ({1'b0, in_chan} < CHAN_LIMIT);

`ifdef ADCFMT_DECIM2_EN
  logic [CHANNELS-1:0] pair_flag;
  logic [WIDTH-1:0]    held [CHANNELS];
  logic [WIDTH:0]      pair_sum;

  // Sign-extend both operands one bit so the sum cannot wrap before the >>>1.
  assign pair_sum  = {held[in_chan][WIDTH-1], held[in_chan]} + {fmt[WIDTH-1], fmt};
  assign enq_data  = pair_sum[WIDTH:1];
  assign enq_valid = in_valid & chan_ok & pair_flag[in_chan];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_flag <= '0;
      for (int i = 0; i < CHANNELS; i++) held[i] <= '0;
    end else if (in_valid && in_ready && chan_ok) begin
      if (pair_flag[in_chan]) begin
        pair_flag[in_chan] <= 1'b0;
      end else begin
        pair_flag[in_chan] <= 1'b1;
        held[in_chan]      <= fmt;
      end
    end
  end
`else
  assign enq_data  = fmt;
  assign enq_valid = in_valid & chan_ok;
`endif

  // Bad-channel samples are still consumed so the ADC side never stalls on them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_err <= 1'b0;
    end else if (in_valid && in_ready && !chan_ok) begin
      chan_err <= 1'b1;
    end
  end

  adcfmt_queue #(
    .DW(ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_valid(enq_valid),
    .push_ready(in_ready),
    .push_data ({enq_data, in_chan}),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (head)
  );

  assign out_data = head[ENTRY_W-1:CW];
  assign out_chan = head[CW-1:0];
  assign out_last = out_valid & (out_chan == LAST_CHAN);

endmodule

// File: doc/adc_sample_formatter.md
# adc_sample_formatter

Parametrised capture-and-format stage between the ADC interface and the non-recursive filter datapath. It accepts raw ADC codes from one or more multiplexed channels with a valid/ready handshake, converts each code to a signed fixed-point word of filter width, and buffers the results in a 2-entry output queue. The queue carries the channel tag with each word, so the filter can stall without losing samples.

## Interface
- `ADC_WIDTH`, 12: raw ADC code width.
- `WIDTH`, 23: output word width, two's complement.
- `FRAC_SHIFT`, 2: number of zero LSBs appended below the ADC code.
- `CHANNELS`, 1: number of multiplexed ADC channels, 1..16.
- `SIGNED_IN`, 0:
  - 0 = unsigned code, zero-extended.
  - 1 = offset-binary code, converted to two's complement by inverting the MSB, then sign-extended.
- Derived `CW` = max(1, clog2(CHANNELS)).
- Elaboration error if ADC_WIDTH+FRAC_SHIFT+1 > WIDTH.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: raw sample present.
- `in_ready` out 1: block can accept; registered.
- `in_data` in ADC_WIDTH: raw ADC code.
- `in_chan` in CW: channel of `in_data`.
- `out_valid` out 1: head of queue valid.
- `out_ready` in 1: consumer takes the head word.
- `out_data` out signed WIDTH: formatted sample.
- `out_chan` out CW: channel tag of `out_data`.
- `out_last` out 1: head word is channel CHANNELS-1.
- `chan_err` out 1: sticky; set when an accepted sample has `in_chan` >= CHANNELS.

## Operation
- Accept on `in_valid & in_ready`. Reject none.
- Format: `ext` = code (or code with MSB inverted) extended to WIDTH. Zero-extend when SIGNED_IN=0, sign-extend when SIGNED_IN=1. Result = `ext` << FRAC_SHIFT. No saturation is needed; the width rule guarantees fit.
- Default parameters reproduce the existing alignment: 9 zero MSBs, then the 12-bit code, then 2 zero LSBs.
- Queue: 2-entry FIFO holding {data, chan}.
  - `in_ready` = count < 2, taken from the registered count.
  - Push and pop in the same cycle leave count unchanged.
  - At count==2 no push occurs; a pop that cycle raises `in_ready` on the next cycle.
- An invalid channel sample is accepted and dropped (never enqueued), and sets `chan_err`. Only reset clears `chan_err`.
- Reset values: `in_ready`=0 while `reset_n` is low, then 1 from the first edge after release. `out_valid`=0, `out_data`=0, `out_chan`=0, `out_last`=0, `chan_err`=0, count=0.
- Reset mid-operation flushes the queue immediately (asynchronous); in-flight samples are lost.

## Timing
- Latency: a sample accepted at edge N is presented with `out_valid`=1 after edge N (registered output), when the queue was empty.
- Throughput: 1 sample/cycle while `out_ready`=1.
- `out_data`/`out_chan` are stable while `out_valid & !out_ready`.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `ADCFMT_DECIM2_EN` defined: per-channel 2:1 decimation.
  - The first accepted sample of a channel is held in a per-channel register and not enqueued.
  - The second produces (a+b)>>>1, computed at WIDTH+1 bits with arithmetic shift (round toward −∞), and is enqueued.
  - Per-channel pair flags and held values reset to 0.
  - Invalid-channel samples do not toggle any flag.
- Undefined: every valid sample is enqueued unchanged. No held registers exist.

## Structure
- Package `adcfmt_pkg`:
  - `clog2`/CW helper function.
  - `SIGNED_IN` encoding constants.
  - Queue entry struct-equivalent width constant (WIDTH+CW).
- Sub-module `adcfmt_queue`: 2-entry FIFO with registered ready, parametrised on entry width.
- Format logic and the decimation path stay in the top module.

## Test plan
- Defaults, `in_data`=0xFFF, `out_ready`=1 → next cycle `out_data`=16380 (0x3FFC), `out_chan`=0, `out_last`=1.
- SIGNED_IN=1: codes 0x000, 0x800, 0xFFF → −8192, 0, 8188.
- CHANNELS=4, `out_ready`=0, stream chans 0,1,2 → `in_ready` falls after 2 accepts. Release `out_ready` → words for chan 0 then 1, `out_last`=0; chan 2 then accepted.
- CHANNELS=3, `in_chan`=3 → `chan_err`=1, no output word. Following chan 0 sample → output normally, `chan_err` stays 1.
- Assert `reset_n` low with 2 queued words → `out_valid` falls immediately without a clock edge, `chan_err`=0. After release, `in_ready`=1 on the first edge.
- With ADCFMT_DECIM2_EN, chan 0 samples 0x001, 0x002 (unsigned) → one word (4+8)>>>1 = 6. SIGNED_IN=1 pair −8192, −8188 → −8190.
